// File: rtl/rcnt_ring.sv
// Parametrised shift/rotate register file with a wrapping parallel tap window,
// fill counter and cumulative rotation pointer.
module rcnt_ring #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int NTAPS = 10,
    parameter int ROT   = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       x,
    input  logic                   shift,
    input  logic [1:0]             mode,
    input  logic                   clear,
    input  logic [AW-1:0]          tap_off,
    output logic [NTAPS*WIDTH-1:0] y,
    output logic [AW:0]            count,
    output logic                   full,
    output logic [AW-1:0]          rot_pos
);

    localparam logic [1:0]    M_SHIFT  = 2'b00;
    localparam logic [1:0]    M_FWD    = 2'b01;
    localparam logic [1:0]    M_BWD    = 2'b10;
    localparam logic [AW:0]   CNT_MAX  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] ROT_STEP = AW'(ROT);

    logic [DEPTH-1:0][WIDTH-1:0] e;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e       <= '0;
            count   <= '0;
            rot_pos <= '0;
        end else if (clear) begin
            e       <= '0;
            count   <= '0;
            rot_pos <= '0;
        end else if (shift) begin
            case (mode)
                M_SHIFT: begin
                    e     <= {e[DEPTH-2:0], x};
                    count <= (count == CNT_MAX) ? count : count + CNT_ONE;
                end
                // Rotations move every slot, including empty ones; count is untouched.
                M_FWD: begin
                    e       <= {e[DEPTH-1-ROT:0], e[DEPTH-1:DEPTH-ROT]};
                    rot_pos <= rot_pos + ROT_STEP;
                end
                M_BWD: begin
                    e       <= {e[ROT-1:0], e[DEPTH-1:ROT]};
                    rot_pos <= rot_pos - ROT_STEP;
                end
                default: ;
            endcase
        end
    end

    assign full = (count == CNT_MAX);

    // Tap index wraps naturally in AW bits.
    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        logic [AW-1:0] idx;
        assign idx                  = tap_off + AW'(k);
        assign y[k*WIDTH +: WIDTH]  = e[idx];
    end

endmodule

// File: tb/tb_rcnt_ring.sv
// Directed bench for rcnt_ring: array model checked every cycle plus literal pins.
module tb_rcnt_ring;

    localparam int WIDTH = 32;
    localparam int DEPTH = 256;
    localparam int NTAPS = 10;
    localparam int ROT   = 2;
    localparam int AW    = 8;
    localparam int YW    = NTAPS * WIDTH;

    logic              clk = 1'b0;
    logic              reset;
    logic [WIDTH-1:0]  x;
    logic              shift;
    logic [1:0]        mode;
    logic              clear;
    logic [AW-1:0]     tap_off;
    logic [YW-1:0]     y;
    logic [AW:0]       count;
    logic              full;
    logic [AW-1:0]     rot_pos;

    rcnt_ring #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NTAPS(NTAPS), .ROT(ROT)) dut (
        .clk(clk), .reset(reset), .x(x), .shift(shift), .mode(mode), .clear(clear),
        .tap_off(tap_off), .y(y), .count(count), .full(full), .rot_pos(rot_pos)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [WIDTH-1:0] m [DEPTH];
    int m_cnt;
    int m_rot;

    task automatic chk(input string name, input logic [YW-1:0] act, input logic [YW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] tap(input int k);
        return y[k*WIDTH +: WIDTH];
    endfunction

    function automatic logic [YW-1:0] exp_y();
        logic [YW-1:0] r;
        for (int k = 0; k < NTAPS; k++)
            r[k*WIDTH +: WIDTH] = m[(int'(tap_off) + k) % DEPTH];
        return r;
    endfunction

    task automatic mdl_zero();
        for (int i = 0; i < DEPTH; i++) m[i] = '0;
        m_cnt = 0;
        m_rot = 0;
    endtask

    task automatic mdl(input bit c, input bit s, input logic [1:0] md, input logic [WIDTH-1:0] xv);
        logic [WIDTH-1:0] t [DEPTH];
        if (c) begin
            mdl_zero();
        end else if (s && md != 2'b11) begin
            for (int i = 0; i < DEPTH; i++) t[i] = m[i];
            case (md)
                2'b00: begin
                    for (int i = 1; i < DEPTH; i++) m[i] = t[i-1];
                    m[0] = xv;
                    if (m_cnt < DEPTH) m_cnt++;
                end
                2'b01: begin
                    for (int i = 0; i < DEPTH; i++) m[(i + ROT) % DEPTH] = t[i];
                    m_rot = (m_rot + ROT) % DEPTH;
                end
                default: begin
                    for (int i = 0; i < DEPTH; i++) m[i] = t[(i + ROT) % DEPTH];
                    m_rot = (m_rot - ROT + DEPTH) % DEPTH;
                end
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("y", y, exp_y());
            chk("count", YW'(count), YW'(m_cnt));
            chk("full", YW'(full), YW'(m_cnt == DEPTH));
            chk("rot_pos", YW'(rot_pos), YW'(m_rot));
        end
    end

    task automatic step(input bit c, input bit s, input logic [1:0] md, input logic [WIDTH-1:0] xv);
        clear = c; shift = s; mode = md; x = xv;
        @(posedge clk);
        mdl(c, s, md, xv);
        #1;
        clear = 1'b0; shift = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mdl_zero();
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; shift = 1'b0; clear = 1'b0; mode = 2'b00; x = '0; tap_off = '0;
        mdl_zero();
        #12;
        chk("rst_y", y, '0);
        chk("rst_count", YW'(count), '0);
        chk("rst_full", YW'(full), '0);
        reset = 1'b1;
        chk_en = 1'b1;

        // 1: ten pushes
        for (int i = 1; i <= 10; i++) step(0, 1, 2'b00, WIDTH'(i));
        for (int k = 0; k < NTAPS; k++) chk("t1_tap", YW'(tap(k)), YW'(10 - k));
        chk("t1_count", YW'(count), YW'(10));
        chk("t1_full", YW'(full), '0);
        chk("t1_rot", YW'(rot_pos), '0);

        // 2: saturation and wrapped taps
        do_reset();
        for (int i = 1; i <= 300; i++) step(0, 1, 2'b00, WIDTH'(i));
        chk("t2_count", YW'(count), YW'(256));
        chk("t2_full", YW'(full), YW'(1));
        tap_off = 8'd250;
        #1;
        for (int k = 0; k < 6; k++) chk("t2_tap_lo", YW'(tap(k)), YW'(50 - k));
        for (int k = 6; k < NTAPS; k++) chk("t2_tap_wrap", YW'(tap(k)), YW'(306 - k));

        // 3: forward then backward rotation
        do_reset();
        tap_off = '0;
        for (int i = 1; i <= 256; i++) step(0, 1, 2'b00, WIDTH'(i));
        step(0, 1, 2'b01, '0);
        chk("t3_e0", YW'(tap(0)), YW'(2));
        chk("t3_e1", YW'(tap(1)), YW'(1));
        chk("t3_e2", YW'(tap(2)), YW'(256));
        chk("t3_rot", YW'(rot_pos), YW'(2));
        chk("t3_count", YW'(count), YW'(256));
        step(0, 1, 2'b10, '0);
        chk("t3_back_e0", YW'(tap(0)), YW'(256));
        chk("t3_back_e1", YW'(tap(1)), YW'(255));
        chk("t3_back_rot", YW'(rot_pos), '0);

        // 4: holds and backward wrap of rot_pos
        for (int i = 0; i < 5; i++) step(0, 0, 2'b00, WIDTH'($urandom));
        step(0, 1, 2'b11, 32'h1234_5678);
        chk("t4_hold_e0", YW'(tap(0)), YW'(256));
        chk("t4_hold_count", YW'(count), YW'(256));
        step(0, 1, 2'b10, '0);
        chk("t4_rot_wrap", YW'(rot_pos), YW'(254));

        // 5: clear beats shift
        do_reset();
        for (int i = 1; i <= 20; i++) step(0, 1, 2'b00, WIDTH'(i * 7));
        step(0, 1, 2'b01, '0);
        step(1, 1, 2'b00, 32'hDEAD);
        chk("t5_y", y, '0);
        chk("t5_count", YW'(count), '0);
        chk("t5_rot", YW'(rot_pos), '0);

        // 6: async reset between edges
        for (int i = 1; i <= 3; i++) step(0, 1, 2'b00, WIDTH'(i + 40));
        step(0, 1, 2'b01, '0);
        #3;
        reset = 1'b0;
        mdl_zero();
        #1;
        chk("t6_y", y, '0);
        chk("t6_count", YW'(count), '0);
        chk("t6_full", YW'(full), '0);
        chk("t6_rot", YW'(rot_pos), '0);
        #2 reset = 1'b1;
        step(0, 1, 2'b00, 32'hA5);
        chk("t6_tap0", YW'(tap(0)), YW'(32'hA5));
        chk("t6_count1", YW'(count), YW'(1));

        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
